universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
//
// PURPOSE
// - WIDTH-bit universal shift register with four modes: hold, shift left,
//   shift right and parallel load.
// - The mode is selected every clock by a 2-bit select input.
// - General-purpose datapath primitive for serializers, scaling and
//   staging registers; registered output, no handshake.
//
// PARAMETERS
// - WIDTH   4  register width in bits; legal values are WIDTH >= 2.
// - ROTATE  0  0 = the vacated bit is filled with 0 (logical shift);
//              1 = the vacated bit takes the bit shifted out (rotate).
//
// PORTS
// - clk      input   1      single clock; all state changes on rising edge.
// - reset    input   1      synchronous, active-low reset (0 = reset).
// - sel      input   2      mode select: 00 hold, 01 left, 10 right, 11 load.
// - data_in  input   WIDTH  parallel load data, used only when sel = 11.
// - q        output  WIDTH  register contents, driven directly from flops.
// - Port order is clk, reset, sel, data_in, q; positional instantiation
//   must work.
//
// BEHAVIOUR
// - One clock; reset is synchronous and active-low.
//   - On a rising edge with reset == 0: q <= 0.
//   - Reset has priority over every sel value.
// - Otherwise, on each rising edge:
//   - sel 00 hold:  q <= q.
//   - sel 01 left:  q <= {q[WIDTH-2:0], fill_l}.
//       fill_l = 0 if ROTATE == 0, else q[WIDTH-1].
//   - sel 10 right: q <= {fill_r, q[WIDTH-1:1]}.
//       fill_r = 0 if ROTATE == 0, else q[0].
//   - sel 11 load:  q <= data_in.
// - Latency: exactly one clock from the sel/data_in sample to the new q.
// - No combinational path from any input to q.
// - Repeated shifts with ROTATE = 0 drain the register to all-zeros.
//   It then stays 0 until a load.
// - Reset asserted mid-sequence clears q on that edge.
//   Operation resumes on the first edge where reset == 1.
// - No X propagation: sel is fully decoded.
//   A default branch that holds q is required for synthesis completeness.
// - Reset value of q is all zeros for every parameter setting.
//
// TESTING
// - 1. Hold reset = 0 for 2 clocks with sel = 11 and data_in = 1010.
//      Required: q = 0000, i.e. reset overrides load.
// - 2. reset = 1, sel = 11, data_in = 1010, 1 clock.
//      Required: q = 1010. Then sel = 01, 1 clock: q = 0100.
// - 3. Continue from 2 (q = 0100). sel = 10, 1 clock: q = 0010.
//      Then sel = 00, 3 clocks: q stays 0010.
// - 4. Load 1001, then sel = 01 for 4 clocks.
//      Required: q = 0010, 0100, 1000, 0000. Then sel = 10: q stays 0000.
// - 5. ROTATE = 1: load 1010.
//      Required: sel = 01 gives q = 0101; then sel = 10 gives q = 1010.
//      Then sel = 10 again gives q = 0101.
// - 6. Load 1111, sel = 01, and drop reset to 0 for one edge.
//      Required: q = 0000 on that edge. Then release reset with sel = 11,
//      data_in = 0110: q = 0110 on the next edge.

Source files
------------

// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit register with hold, shift left, shift right and parallel load
module universal_shift_register #(
    parameter int WIDTH  = 4,
    parameter int ROTATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             fill_l, fill_r;
    always_comb begin
        fill_l = (ROTATE != 0) ? q_q[WIDTH-1] : 1'b0;
        fill_r = (ROTATE != 0) ? q_q[0] : 1'b0;
        case (sel)
            2'b01:   q_d = {q_q[WIDTH-2:0], fill_l};
            2'b10:   q_d = {fill_r, q_q[WIDTH-1:1]};
            2'b11:   q_d = data_in;
            default: q_d = q_q;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) q_q <= '0;
        else        q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: checks logical (q0) and rotating (q1) instances against an arithmetic model
module tb_universal_shift_register;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] q0, q1;
    logic [W-1:0] m0 = '0, m1 = '0;
    int errors = 0;
    int checks = 0;

    universal_shift_register #(.WIDTH(W), .ROTATE(0)) dut0 (
        .clk(clk), .reset(reset), .sel(sel), .data_in(data_in), .q(q0));
    universal_shift_register #(.WIDTH(W), .ROTATE(1)) dut1 (
        .clk(clk), .reset(reset), .sel(sel), .data_in(data_in), .q(q1));

    always #5 clk = ~clk;

    // Shifts expressed as multiply/divide by two on the unsigned value
    function automatic logic [W-1:0] model(input logic [W-1:0] cur, input bit rot,
                                           input logic rst_n, input logic [1:0] s,
                                           input logic [W-1:0] d);
        int v, top;
        v = int'(cur);
        top = 1 << (W - 1);
        if (!rst_n) return '0;
        case (s)
            2'b01:   return W'((v * 2) % (2 * top) + (rot ? v / top : 0));
            2'b10:   return W'(v / 2 + (rot ? (v % 2) * top : 0));
            2'b11:   return d;
            default: return cur;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic [1:0] s, input logic [W-1:0] d);
        @(negedge clk);
        reset = r; sel = s; data_in = d;
        m0 = model(m0, 1'b0, r, s, d);
        m1 = model(m1, 1'b1, r, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 2'b11, 4'b1010);
            checks++;
            if (q0 !== 4'b0000) begin errors++; $display("FAIL reset_q0[%0d]: got %b want 0000", i, q0); end
            checks++;
            if (q1 !== 4'b0000) begin errors++; $display("FAIL reset_q1[%0d]: got %b want 0000", i, q1); end
        end
    endtask

    task automatic test_load_left;
        cycle(1'b1, 2'b11, 4'b1010);
        checks++;
        if (q0 !== 4'b1010) begin errors++; $display("FAIL load: got %b want 1010", q0); end
        cycle(1'b1, 2'b01, 4'b0000);
        checks++;
        if (q0 !== 4'b0100) begin errors++; $display("FAIL left: got %b want 0100", q0); end
        checks++;
        if (q1 !== 4'b0101) begin errors++; $display("FAIL left_rot: got %b want 0101", q1); end
    endtask

    task automatic test_right_hold;
        cycle(1'b1, 2'b10, 4'b1111);
        checks++;
        if (q0 !== 4'b0010) begin errors++; $display("FAIL right: got %b want 0010", q0); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b00, 4'b1111);
            checks++;
            if (q0 !== 4'b0010) begin errors++; $display("FAIL hold[%0d]: got %b want 0010", i, q0); end
            checks++;
            if (q1 !== m1) begin errors++; $display("FAIL hold_rot[%0d]: got %b want %b", i, q1, m1); end
        end
    endtask

    task automatic test_drain;
        logic [W-1:0] exp [4];
        exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};
        cycle(1'b1, 2'b11, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'b01, 4'b1111);
            checks++;
            if (q0 !== exp[i]) begin errors++; $display("FAIL drain[%0d]: got %b want %b", i, q0, exp[i]); end
            checks++;
            if (q1 !== m1) begin errors++; $display("FAIL drain_rot[%0d]: got %b want %b", i, q1, m1); end
        end
        cycle(1'b1, 2'b10, 4'b1111);
        checks++;
        if (q0 !== 4'b0000) begin errors++; $display("FAIL drained_right: got %b want 0000", q0); end
    endtask

    task automatic test_rotate;
        logic [W-1:0] exp [3];
        logic [1:0]   s [3];
        exp = '{4'b0101, 4'b1010, 4'b0101};
        s   = '{2'b01, 2'b10, 2'b10};
        cycle(1'b1, 2'b11, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, s[i], 4'b0000);
            checks++;
            if (q1 !== exp[i]) begin errors++; $display("FAIL rotate[%0d]: got %b want %b", i, q1, exp[i]); end
        end
        checks++;
        if (q0 !== m0) begin errors++; $display("FAIL rotate_logical: got %b want %b", q0, m0); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 2'b11, 4'b1111);
        cycle(1'b0, 2'b01, 4'b1111);
        checks++;
        if (q0 !== 4'b0000) begin errors++; $display("FAIL mid_reset_q0: got %b want 0000", q0); end
        checks++;
        if (q1 !== 4'b0000) begin errors++; $display("FAIL mid_reset_q1: got %b want 0000", q1); end
        cycle(1'b1, 2'b11, 4'b0110);
        checks++;
        if (q0 !== 4'b0110) begin errors++; $display("FAIL resume_q0: got %b want 0110", q0); end
        checks++;
        if (q1 !== 4'b0110) begin errors++; $display("FAIL resume_q1: got %b want 0110", q1); end
    endtask

    task automatic test_random;
        logic [W-1:0] p0, p1;
        logic         r;
        logic [1:0]   s;
        logic [W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) != 0);
            s = 2'($urandom_range(0, 3));
            d = W'($urandom);
            @(negedge clk);
            p0 = m0; p1 = m1;
            reset = r; sel = s; data_in = d;
            #1;
            checks++;
            if (q0 !== p0 || q1 !== p1) begin
                errors++; $display("FAIL no_comb[%0d]: got %b/%b want %b/%b", i, q0, q1, p0, p1);
            end
            m0 = model(m0, 1'b0, r, s, d);
            m1 = model(m1, 1'b1, r, s, d);
            @(posedge clk);
            #1;
            checks++;
            if (q0 !== m0) begin errors++; $display("FAIL rand_q0[%0d]: got %b want %b", i, q0, m0); end
            checks++;
            if (q1 !== m1) begin errors++; $display("FAIL rand_q1[%0d]: got %b want %b", i, q1, m1); end
        end
    endtask

    initial begin
        test_reset;
        test_load_left;
        test_right_hold;
        test_drain;
        test_rotate;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
